// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add/subtract sequencer.
package serial_add_pkg;

    // Sequencer states; encoding fixed here so every user agrees on it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter width for a given operand width (at least one bit).
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Combinational half adder; two of them plus an OR form one full-adder slice.
module half_adder_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract engine: one full-adder slice walked LSB first over WIDTH cycles.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic p;
    logic g;
    logic s_bit;
    logic pc;
    logic c_next;
    logic last_bit;
    logic accept;

    // Full-adder slice on the current LSBs: propagate/generate, then fold in carry.
    half_adder_cell u_ha_pg (
        .x (a_sr[0]),
        .y (b_sr[0]),
        .s (p),
        .c (g)
    );

    half_adder_cell u_ha_sum (
        .x (p),
        .y (carry),
        .s (s_bit),
        .c (pc)
    );

    assign c_next   = g | pc;
    assign last_bit = (cnt == CNT_LAST);
    assign accept   = (state_q == ST_IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE always returns to IDLE so a held start cannot skip ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch, serial shift, carry/count and result capture on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            // Subtract is a + ~b + 1: the +1 enters through the initial carry.
            a_sr  <= a;
            b_sr  <= op_sub ? ~b : b;
            acc   <= '0;
            carry <= op_sub;
            cnt   <= '0;
        end else if (state_q == ST_RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            acc   <= {s_bit, acc[WIDTH-1:1]};
            carry <= c_next;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
                sum_q  <= {s_bit, acc[WIDTH-1:1]};
                cout_q <= c_next;
            end
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer at WIDTH=8.
module tb_serial_add_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       op_sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int total  = 0;
    int passed = 0;

    serial_add_sequencer #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full operation from IDLE with cycle-exact handshake checks.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic sub,
                         input logic [7:0] es, input logic ec, input string tag);
        a = ta; b = tb_v; op_sub = sub; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " busy after accept"}, busy, 1'b1);
        chk({tag, " ready after accept"}, ready, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 8) chk({tag, " no early done"}, {busy, done}, 2'b10);
        end
        chk({tag, " done pulse"}, {busy, done, ready}, 3'b010);
        chk({tag, " sum"}, sum, es);
        chk({tag, " cout"}, cout, ec);
        tick();
        chk({tag, " ready back"}, {ready, done}, 2'b10);
    endtask

    int done_cnt;
    int last_done;

    initial begin
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset ctrl", {ready, busy, done}, 3'b100);
        chk("reset sum", sum, 8'h00);
        chk("reset cout", cout, 1'b0);

        do_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, "add5A33");
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "addFF01");
        do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "add8080");
        do_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, "sub1001");
        do_op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, "sub0102");
        do_op(8'h77, 8'h77, 1'b1, 8'h00, 1'b1, "sub7777");

        // Start and operand changes while busy and in DONE are ignored.
        a = 8'h05; b = 8'h03; op_sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) begin a = 8'hAA; b = 8'h55; start = 1'b1; end
            if (i == 5) begin a = 8'h11; b = 8'hEE; op_sub = 1'b1; end
            tick();
            start = 1'b0;
            if (i < 8) chk("busy ign no done", {busy, done}, 2'b10);
        end
        chk("busy ign done", done, 1'b1);
        chk("busy ign sum", sum, 8'h08);
        chk("busy ign cout", cout, 1'b0);
        a = 8'hAA; b = 8'h55; op_sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("done-start ready", {ready, busy, done}, 3'b100);
        tick();
        chk("done-start not accepted", {ready, busy, done}, 3'b100);
        chk("done-start sum hold", sum, 8'h08);

        // Reset in the middle of an operation.
        a = 8'hF0; b = 8'h0F; op_sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort ctrl", {ready, busy, done}, 3'b100);
        chk("abort sum", sum, 8'h00);
        chk("abort cout", cout, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("abort no done", done_cnt, 0);

        // Start held high: one accept every 10 cycles.
        a = 8'h01; b = 8'h01; op_sub = 1'b0; start = 1'b1;
        done_cnt = 0;
        last_done = -1;
        for (int t = 1; t <= 35; t++) begin
            tick();
            if (done) begin
                done_cnt++;
                chk("b2b sum", sum, 8'h02);
                chk("b2b cout", cout, 1'b0);
                if (last_done < 0) chk("b2b first done", t, 9);
                else chk("b2b spacing", t - last_done, 10);
                last_done = t;
            end
        end
        start = 1'b0;
        chk("b2b done count", done_cnt, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Bit-serial add/subtract engine. Sequences a pair of half-adder cells (chained as a full adder) over WIDTH cycles, LSB first, for two latched WIDTH-bit operands.
- Start/ready/done handshake. Sits between the tile I/O pins and the shared adder cells, replacing per-bit parallel adder logic.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request; accepted only when ready=1
- op_sub  input  1  0=add (a+b), 1=subtract (a-b); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN only
- done  output  1  one-cycle pulse; result just updated
- sum  output  WIDTH  result; holds the last completed operation
- cout  output  1  final carry out; for subtract, 1 = no borrow (a>=b unsigned)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, shift registers, carry and counter cleared. Reset takes priority over every other event, including mid-RUN; the aborted operation produces no done.
- States: IDLE, RUN, DONE. Encoding is localparam/enum in the package.
- IDLE:
  - start=1 at an edge: latch a into a_sr; latch b (or ~b if op_sub) into b_sr.
  - Set carry=op_sub and cnt=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Combinational bit slice:
    - p = a_sr[0]^b_sr[0]
    - g = a_sr[0]&b_sr[0]
    - s = p^carry
    - c_next = g | (p&carry)
    - Implemented as two half_adder_cell instances plus one OR.
  - Registers: a_sr and b_sr shift right by 1; acc = {s, acc[WIDTH-1:1]}; carry=c_next; cnt=cnt+1.
  - When cnt==WIDTH-1 on this edge: load sum with the final shifted acc value (including this bit) and cout with c_next; go to DONE.
- DONE: done=1 for exactly this cycle; ready=0; next edge goes to IDLE unconditionally.
- Latency:
  - Start accepted at edge k. RUN occupies cycles k+1..k+WIDTH.
  - done is high in the cycle following edge k+WIDTH. sum/cout change only at that same edge.
  - Minimum start-to-start period is WIDTH+2 cycles.
- start while busy or in DONE: ignored, with no effect on the operation in progress or on sum/cout. Operands are not re-sampled.
- a, b, op_sub may change freely after acceptance; the latched copies are used.
- Arithmetic is modulo 2^WIDTH; overflow is reported only via cout.
- Counter width is $clog2(WIDTH); it wraps to 0 on acceptance, never past WIDTH-1.
- ready, busy and done are decoded directly from the state register (glitch-free, registered).
- All uio pins of the enclosing tile wrapper are unused by this block.

Decomposition:
- Package serial_add_pkg:
  - state type (IDLE/RUN/DONE) and state localparams
  - function cnt_width(WIDTH)
- Sub-module half_adder_cell: combinational, inputs x, y; outputs s=x^y, c=x&y.
  - Instantiated twice for the bit slice.
  - Reusable by other tiles.
- All sequencing (FSM, shift registers, counter, result registers) lives in serial_add_sequencer.

Test Plan (WIDTH=8):
- Reset then add: a=0x5A, b=0x33, op_sub=0, start pulse at edge k -> busy for 8 cycles; done only in the cycle after edge k+8; sum=0x8D, cout=0; ready returns the following cycle.
- Overflow: a=0xFF, b=0x01, add -> sum=0x00, cout=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1.
- Subtract:
  - a=0x10, b=0x01, op_sub=1 -> sum=0x0F, cout=1.
  - a=0x01, b=0x02, op_sub=1 -> sum=0xFF, cout=0.
  - a=b=0x77 -> sum=0x00, cout=1.
- Start/operand changes while busy: start a=0x05+b=0x03; pulse start with a=0xAA, b=0x55 on cycles 3 and 9 (the DONE cycle); change a/b mid-RUN -> single done, sum=0x08. The second request is not accepted, and sum holds 0x08 afterwards.
- Reset mid-operation: previous result sum=0x08; start 0xF0+0x0F; assert rst at the 4th RUN edge -> next cycle state IDLE, ready=1, sum=0, cout=0; no done pulse ever appears for the aborted op.
- Back-to-back: start held high with a=0x01, b=0x01, add -> an operation is accepted every 10 cycles; done pulses are spaced exactly 10 cycles apart; sum=0x02 each time; no done is missed or duplicated.
